// File: rtl/pipe_stage_chain_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_chain_if
// Brief    : Handshake, stall and flush bundle for the elastic stage chain.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_stage_chain_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 3
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic                 hold;
  logic [DEPTH-1:0]     flush_mask;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [DEPTH-1:0]     stage_valid;
  logic [OCC_W-1:0]     occupancy;

  modport master (
    output hold, flush_mask, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, stage_valid, occupancy
  );

  modport slave (
    input  hold, flush_mask, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, stage_valid, occupancy
  );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_chain.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_chain
// Brief    : Elastic DEPTH-stage pipeline register chain with valid/ready,
//            bubble collapsing, global hold and per-stage flush.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_chain #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 3,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_stage_chain_if.slave bus
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]             r_v;
  logic [DEPTH-1:0][WIDTH-1:0]  r_data;
  logic [OCC_W-1:0]             r_occ;

  logic [DEPTH-1:0]             w_en;
  logic [DEPTH-1:0]             w_pv;
  logic [DEPTH-1:0][WIDTH-1:0]  w_pd;
  logic [DEPTH-1:0]             w_v_nxt;
  logic [DEPTH-1:0][WIDTH-1:0]  w_d_nxt;
  logic [OCC_W-1:0]             w_occ_nxt;

  // A flushed predecessor presents valid=0 so its payload never propagates.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign w_pv[i] = bus.in_valid;
      assign w_pd[i] = bus.in_data;
    end else begin : g_body
      assign w_pv[i] = r_v[i-1] & ~bus.flush_mask[i-1];
      assign w_pd[i] = r_data[i-1];
    end
  end

  always_comb begin
    w_en[DEPTH-1] = ~r_v[DEPTH-1] | bus.out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      w_en[i] = ~r_v[i] | w_en[i+1];
    end

    w_v_nxt   = r_v;
    w_d_nxt   = r_data;
    w_occ_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.flush_mask[i]) begin
        w_v_nxt[i] = 1'b0;
        if (CLEAR_DATA) begin
          w_d_nxt[i] = '0;
        end
      end else if (!bus.hold && w_en[i]) begin
        w_v_nxt[i] = w_pv[i];
        w_d_nxt[i] = w_pd[i];
      end
      w_occ_nxt = w_occ_nxt + OCC_W'(w_v_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v    <= '0;
      r_data <= '0;
      r_occ  <= '0;
    end else begin
      r_v    <= w_v_nxt;
      r_data <= w_d_nxt;
      r_occ  <= w_occ_nxt;
    end
  end

  assign bus.in_ready    = w_en[0] & ~bus.hold & ~bus.flush_mask[0];
  assign bus.out_valid   = r_v[DEPTH-1] & ~bus.hold & ~bus.flush_mask[DEPTH-1];
  assign bus.out_data    = r_data[DEPTH-1];
  assign bus.stage_valid = r_v;
  assign bus.occupancy   = r_occ;
endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_chain.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_chain
// Brief    : Directed plus randomized bench with slot-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_chain;
  localparam int WIDTH = 16;
  localparam int DEPTH = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_stage_chain_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  pipe_stage_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CLEAR_DATA(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic             mv [DEPTH];
  logic [WIDTH-1:0] md [DEPTH];
  int               mocc;
  logic [WIDTH-1:0] sbq [$];
  bit               sb_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // A slot can advance if any slot at or after it is empty, or the sink takes.
  function automatic bit space(input int i);
    if (bus.out_ready) return 1'b1;
    for (int j = i; j < DEPTH; j++) if (!mv[j]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic tick();
    logic [DEPTH-1:0] sv;
    bit               ir, ov, pv;
    logic             nv [DEPTH];
    logic [WIDTH-1:0] nd [DEPTH];
    logic [WIDTH-1:0] pd;
    int               cnt;
    @(negedge clk);
    ir = !bus.hold && !bus.flush_mask[0] && space(0);
    ov = mv[DEPTH-1] && !bus.hold && !bus.flush_mask[DEPTH-1];
    for (int i = 0; i < DEPTH; i++) sv[i] = mv[i];
    chk("in_ready", 32'(bus.in_ready), 32'(ir));
    chk("out_valid", 32'(bus.out_valid), 32'(ov));
    chk("stage_valid", 32'(bus.stage_valid), 32'(sv));
    chk("occupancy", 32'(bus.occupancy), 32'(mocc));
    if (mv[DEPTH-1]) chk("out_data", 32'(bus.out_data), 32'(md[DEPTH-1]));
    if (sb_en && rst_n) begin
      if (ov && bus.out_ready) begin
        checks++;
        assert (sbq.size() > 0) else begin
          errors++;
          $error("FAIL sb_underflow: observed %h expected nonempty", bus.out_data);
        end
        if (sbq.size() > 0) chk("sb_order", 32'(bus.out_data), 32'(sbq.pop_front()));
      end
      if (ir && bus.in_valid) sbq.push_back(bus.in_data);
    end
    @(posedge clk);
    cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      pv = (i == 0) ? bus.in_valid : (mv[i-1] && !bus.flush_mask[i-1]);
      pd = (i == 0) ? bus.in_data : md[i-1];
      nv[i] = mv[i];
      nd[i] = md[i];
      if (!rst_n || bus.flush_mask[i]) begin
        nv[i] = 1'b0;
        nd[i] = '0;
      end else if (!bus.hold && space(i)) begin
        nv[i] = pv;
        nd[i] = pd;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      mv[i] = nv[i];
      md[i] = nd[i];
      cnt += int'(nv[i]);
    end
    mocc = cnt;
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mv[i] = 1'bx;
      md[i] = 'x;
    end
    mocc           = 0;
    rst_n          = 1'b0;
    bus.hold       = 1'b0;
    bus.flush_mask = '0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      mv[i] = 1'b0;
      md[i] = '0;
    end
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_occ", 32'(bus.occupancy), 32'd0);
    rst_n = 1'b1;

    // Stream with sink always ready.
    bus.out_ready = 1'b1;
    push(16'h1111);
    chk("lat_1", 32'(bus.out_valid), 32'd0);
    push(16'h2222);
    chk("lat_2", 32'(bus.out_valid), 32'd0);
    push(16'h3333);
    chk("lat_3_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_3_data", 32'(bus.out_data), 32'h1111);
    chk("stream_occ", 32'(bus.occupancy), 32'd3);
    idle(3);
    chk("stream_empty", 32'(bus.occupancy), 32'd0);

    // Backpressure fill and bubble-free refill.
    bus.out_ready = 1'b0;
    push(16'h1111);
    push(16'h2222);
    push(16'h3333);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h4444;
    #1;
    chk("bp_full_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_full_occ", 32'(bus.occupancy), 32'd3);
    tick();
    bus.out_ready = 1'b1;
    #1;
    chk("bp_refill_ready", 32'(bus.in_ready), 32'd1);
    chk("bp_refill_data", 32'(bus.out_data), 32'h1111);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_refill_occ", 32'(bus.occupancy), 32'd3);
    idle(4);

    // Bubble collapse under backpressure.
    bus.out_ready = 1'b0;
    push(16'h00A0);
    idle(1);
    push(16'h00B0);
    idle(1);
    chk("bubble_sv", 32'(bus.stage_valid), 32'b110);
    chk("bubble_occ", 32'(bus.occupancy), 32'd2);
    push(16'h00C0);
    chk("bubble_full", 32'(bus.stage_valid), 32'b111);

    // Hold with a full chain, then resume.
    bus.hold      = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h5555;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_out_valid", 32'(bus.out_valid), 32'd0);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      chk("hold_data", 32'(bus.out_data), 32'h00A0);
      chk("hold_occ", 32'(bus.occupancy), 32'd3);
    end
    bus.hold = 1'b0;
    tick();
    bus.in_data = 16'h6666;
    tick();
    bus.in_valid = 1'b0;
    idle(5);
    chk("hold_drained", 32'(bus.occupancy), 32'd0);

    // Selective flush of the two youngest stages.
    bus.out_ready = 1'b0;
    push(16'hAAAA);
    push(16'hBBBB);
    push(16'hCCCC);
    bus.flush_mask = 3'b011;
    #1;
    chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    bus.flush_mask = '0;
    chk("flush_sv", 32'(bus.stage_valid), 32'b100);
    chk("flush_d0", 32'(dut.r_data[0]), 32'd0);
    chk("flush_d1", 32'(dut.r_data[1]), 32'd0);
    chk("flush_keep", 32'(bus.out_data), 32'hAAAA);
    bus.out_ready = 1'b1;
    idle(2);

    // Reset mid-operation on a full chain.
    bus.out_ready = 1'b0;
    push(16'h0101);
    push(16'h0202);
    push(16'h0303);
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0404;
    tick();
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    chk("mrst_occ", 32'(bus.occupancy), 32'd0);
    chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_out_data", 32'(bus.out_data), 32'd0);
    chk("mrst_sv", 32'(bus.stage_valid), 32'd0);

    // Random traffic with hold, scoreboarded for order and loss.
    sbq.delete();
    sb_en = 1'b1;
    for (int k = 0; k < 400; k++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = 16'($urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.hold      = ($urandom_range(0, 7) == 0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.hold      = 1'b0;
    bus.out_ready = 1'b1;
    idle(DEPTH + 2);
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    sb_en = 1'b0;

    // Random traffic with flushes and occasional resets.
    for (int k = 0; k < 400; k++) begin
      bus.in_valid   = 1'($urandom_range(0, 1));
      bus.in_data    = 16'($urandom);
      bus.out_ready  = 1'($urandom_range(0, 1));
      bus.hold       = ($urandom_range(0, 5) == 0);
      bus.flush_mask = ($urandom_range(0, 4) == 0) ? DEPTH'($urandom) : '0;
      rst_n          = ($urandom_range(0, 40) != 0);
      tick();
    end
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised, elastic pipeline-register chain. It is the generic successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches.
- Carries a WIDTH-bit payload through DEPTH stages. Each stage has its own valid bit.
- Uses a valid/ready handshake with bubble collapsing, a global hold (cache-miss stall) and per-stage selective flush (branch squash).
- Sits between pipeline functional units. It also serves as the staging buffer for the multi-cycle cache/memory interface.

Parameters:
WIDTH, 16, payload width in bits (instruction/PC/control bundle).
DEPTH, 3, number of register stages (>=1); stage 0 is youngest, stage DEPTH-1 drives the output.
CLEAR_DATA, 1, 1 = payload of a flushed or reset stage is forced to zero; 0 = payload keeps its value, only valid is cleared.

Ports:
clk  input  1  clock, all state updates on rising edge.
rst_n  input  1  synchronous active-low reset.
hold  input  1  global stall: freezes every stage.
flush_mask  input  DEPTH  bit i = squash stage i this cycle.
in_valid  input  1  upstream has a payload.
in_ready  output  1  chain accepts the payload this cycle.
in_data  input  WIDTH  upstream payload.
out_valid  output  1  stage DEPTH-1 holds a consumable payload.
out_ready  input  1  downstream consumes this cycle.
out_data  output  WIDTH  payload of stage DEPTH-1.
stage_valid  output  DEPTH  raw valid bit of each stage.
occupancy  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Reset: when rst_n=0 at a clock edge, all valid bits go to 0, all payloads go to 0 (regardless of CLEAR_DATA) and occupancy goes to 0. Outputs then read in_ready=1, out_valid=0, out_data=0. Reset mid-stream discards all contents.
- Enable chain (combinational, hold=0):
  - en[DEPTH-1] = ~v[DEPTH-1] | out_ready.
  - en[i] = ~v[i] | en[i+1].
  - A stage loads from its predecessor (stage 0 loads from in_data/in_valid) when en[i]=1.
  - When a stage loads, the new valid bit is the predecessor's valid bit, so bubbles collapse.
- Handshake signals:
  - in_ready = en[0] & ~hold & ~flush_mask[0].
  - out_valid = v[DEPTH-1] & ~hold & ~flush_mask[DEPTH-1].
  - An input transfer occurs when in_valid & in_ready; an output transfer occurs when out_valid & out_ready.
  - in_ready may depend combinationally on out_ready. Upstream must not make in_valid depend on in_ready.
- Throughput and latency:
  - One payload per cycle sustained when out_ready=1.
  - An empty chain presents a payload at the output DEPTH cycles after acceptance.
  - A payload never skips a stage.
- Hold:
  - All en forced to 0 and no state changes.
  - in_ready=0 and out_valid=0; out_ready is ignored.
  - out_data and stage_valid keep their values.
- Flush:
  - flush_mask[i]=1 sets v[i] to 0 at the edge, and the payload to 0 if CLEAR_DATA=1.
  - Any payload that would move into a flushed stage is dropped.
  - A payload in a flushed stage does not propagate onward: its successor sees valid=0 from it.
  - Flush has priority over hold and over movement.
  - Flush-during-hold clears only the masked stages; the others stay frozen.
- Priority per stage: reset > flush > hold > load > retain.
- Occupancy: registered popcount of the next valid vector, updated every edge. Its maximum is DEPTH; no overflow is possible.
- Invalid stages: their payload is don't-care when CLEAR_DATA=0.

Test Plan:
- Reset then stream: DEPTH=3, out_ready=1, push 0x1111, 0x2222, 0x3333 on consecutive cycles -> out_valid rises 3 cycles after the first accept, outputs appear in order one per cycle, occupancy stays at 3 while streaming.
- Backpressure fill: out_ready=0, push 4 items -> first 3 accepted, in_ready=0 on the 4th, occupancy=3. Raise out_ready -> 0x1111 leaves on the same cycle and the 4th item is accepted that cycle (bubble-free refill).
- Bubble collapse: push A, gap, B with out_ready=0 -> after 3 cycles stage_valid=3'b110 and occupancy=2. A 3rd push C is accepted, giving stage_valid=3'b111.
- Hold: full chain with hold=1 for 5 cycles while out_ready=1 and in_valid=1 -> out_valid=0, in_ready=0, contents and occupancy unchanged. After release, the stream resumes with no loss or duplication.
- Selective flush: chain holds A (stage 2), B (1), C (0), flush_mask=3'b011 with out_ready=0 -> next cycle stage_valid=3'b100, stage 0/1 payloads are 0 (CLEAR_DATA=1), A is intact, in_ready was 0 during the flush cycle.
- Reset mid-operation: full chain, rst_n=0 for 1 cycle coincident with in_valid=1 and flush_mask=0 -> next cycle occupancy=0, out_valid=0, out_data=0, the input is not accepted.
